ppu_requant: RTL and testbench
==============================

Name: ppu_requant

Overview:
- Consumer side of the PE opsum interface: takes the signed 32-bit opsum/valid stream from the PE array and accumulates ACC_LEN partial sums per output pixel.
- Requantizes each sum to int8 (scale, shift, round, zero-point, saturate).
- Packs four int8 results into a 32-bit word for the output buffer writer, using a valid/ready handshake.
- Sits between the PE array and the ofmap SRAM writer.

Parameters:
- ACC_LEN, 9, opsums summed per output element (e.g. 3x3 kernel); must be >= 1.
- SCALE_W, 16, width of unsigned requant multiplier.
- SHIFT_W, 5, width of right-shift amount (0..31).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clr  in  1  synchronous clear: drops partial group and partially packed word
- opsum_in  in  32  signed partial sum from PE
- opsum_valid  in  1  opsum_in valid
- opsum_ready  out  1  block can accept opsum this cycle
- scale  in  SCALE_W  unsigned multiplier; quasi-static
- shift  in  SHIFT_W  arithmetic right shift; quasi-static
- zero_point  in  8  signed output zero point; quasi-static
- out_data  out  32  four packed int8; first result in [7:0], fourth in [31:24]
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data

Behaviour:
- Reset (async, rst=1): all outputs and internal registers are 0.
  - opsum_ready=0 during reset; it is 1 from the first edge after release, since nothing is pending.
  - grp_cnt=0, lane=0, pipeline valids=0.
- Stall:
  - stall = out_valid & ~out_ready.
  - opsum_ready = ~stall.
  - While stalled, every register holds (accumulator, stage valids, lane regs, out_data).
- Accept: an opsum is accepted when opsum_valid & opsum_ready.
- Stage A (accumulate):
  - 32-bit two's-complement wrap; no saturation.
  - On accept with grp_cnt==0: acc <= opsum_in. Otherwise acc <= acc + opsum_in.
  - grp_cnt increments per accept. At grp_cnt==ACC_LEN-1:
    - sum_reg <= acc + opsum_in (or opsum_in if ACC_LEN==1);
    - a_vld <= 1;
    - grp_cnt <= 0.
  - Otherwise a_vld <= 0.
- Stage B (requant), registered, one cycle after a_vld:
  - prod = sum_reg * {0,scale}, 48-bit signed.
  - r = (prod + (shift!=0 ? 1<<(shift-1) : 0)) >>> shift (round half up).
  - v = r + zero_point (sign-extended).
  - q = clamp(v, -128, 127).
  - b_vld <= a_vld.
- Stage C (pack):
  - On b_vld with lane<3: lane_reg[lane] <= q; lane <= lane+1.
  - On b_vld with lane==3: out_data <= {q, lane_reg[2], lane_reg[1], lane_reg[0]}; out_valid <= 1; lane <= 0.
  - out_valid clears on out_valid & out_ready unless a new word completes in the same cycle. A stall cannot coincide with completion.
- Latency:
  - Final opsum of a group is accepted at edge E0.
  - Requant result is registered at E1 and packed at E2.
  - out_valid is high after E2 when that result is the 4th lane.
- Throughput: one opsum per cycle when not stalled; no bubbles.
- clr (sync, priority below rst):
  - grp_cnt, lane, a_vld, b_vld <= 0.
  - out_valid and out_data are unaffected, so a completed word still handshakes.
- Simultaneous clr and accept: clr wins; the opsum is dropped.
- Config: scale, shift and zero_point must be held stable while any group is in flight. They are sampled in stage B.

Optional Feature:
- Macro: PPU_RELU_EN.
- Defined: lower clamp bound becomes max(-128, zero_point), i.e. quantized-domain ReLU. The upper bound stays 127.
- Undefined: clamp to [-128, 127] only; no extra logic.

Test Plan:
- Defaults, scale=1, shift=0, zp=0; 36 opsums of value 10 -> four sums of 90 -> one word out_data=0x5A5A5A5A. out_valid rises 2 edges after the 36th accept.
- Rounding with scale=3, shift=2:
  - sum 90 -> 68 (0x44);
  - sum -90 -> -67 (0xBD);
  - packed with two zeros (sum 0) -> 0x0000BD44 (first result in low byte).
- Saturation:
  - sum 1000 -> 0x7F;
  - sum -1000 -> 0x80;
  - zp=10 with sum 120 -> 0x7F;
  - acc wrap: 0x7FFFFFFF + 1 -> negative, clamps to 0x80.
- Backpressure: hold out_ready=0 after a word completes.
  - opsum_ready must read 0 next cycle, and out_data must stay stable for 20 cycles.
  - Release out_ready -> the word handshakes once; the next 4 groups produce the correct next word with no loss or duplication.
- Reset/clr mid-operation:
  - rst asserted asynchronously after 5 opsums -> all outputs 0 immediately.
  - After release, the next 9 opsums form a full group.
  - clr after 2 packed lanes -> the next word contains only post-clr results.
- PPU_RELU_EN with zp=5, sum -50: defined -> byte 0x05; undefined -> byte 0xD3 (-45).

Source files
------------

// File: rtl/ppu_requant.sv
// ppu_requant
//
// Post-processing unit that sits between the PE array and the ofmap SRAM
// writer. It takes the signed 32-bit opsum stream from the PE array and
// sums ACC_LEN partial sums into one output element. It requantizes each
// sum to int8 (scale, shift with round-half-up, zero point, saturate).
// It then packs four int8 results into one 32-bit word, with the first
// result in the low byte.
//
// Optional feature: define PPU_RELU_EN to raise the lower clamp bound from
// -128 to zero_point. This is a ReLU in the quantized domain.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   clr          synchronous clear of the partial group and partial word
//   opsum_in     signed partial sum from the PE array
//   opsum_valid  opsum_in is valid
//   opsum_ready  block accepts an opsum this cycle
//   scale        unsigned requant multiplier (quasi-static)
//   shift        arithmetic right-shift amount (quasi-static)
//   zero_point   signed output zero point (quasi-static)
//   out_data     four packed int8 results
//   out_valid    out_data is valid
//   out_ready    downstream accepts out_data
module ppu_requant #(
    parameter int ACC_LEN = 9,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [31:0]        opsum_in,
    input  logic               opsum_valid,
    output logic               opsum_ready,
    input  logic [SCALE_W-1:0] scale,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [7:0]         zero_point,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

    logic              rdy_q;
    logic              stall;
    logic              accept;
    logic [CNT_W-1:0]  grp_cnt;
    logic [31:0]       acc;
    logic [31:0]       sum_next;
    logic [31:0]       sum_reg;
    logic              a_vld;
    logic [7:0]        q_next;
    logic [7:0]        q_reg;
    logic              b_vld;
    logic [1:0]        lane;
    logic [7:0]        lane_reg [3];

    logic signed [47:0] sum_ext;
    logic signed [47:0] scale_ext;
    logic signed [47:0] prod;
    logic signed [47:0] rnd;
    logic signed [47:0] shifted;
    logic signed [47:0] zp_ext;
    logic signed [47:0] v;
    logic signed [47:0] lo;

    // The whole pipeline freezes while a finished word waits downstream.
    // rdy_q keeps opsum_ready low during reset and until the first clock
    // edge after reset is released.
    assign stall       = out_valid & ~out_ready;
    assign opsum_ready = rdy_q & ~stall;
    assign accept      = opsum_valid & opsum_ready;

    // A group's first opsum replaces the accumulator instead of adding to
    // it. This way nothing needs to clear the accumulator between groups.
    assign sum_next = (grp_cnt == '0) ? opsum_in : acc + opsum_in;

    // Ready enable: goes high on the first edge after reset and stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Stage A: accumulate ACC_LEN opsums. Hand the finished sum to stage B
    // as a one-cycle a_vld pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_cnt <= '0;
            acc     <= '0;
            sum_reg <= '0;
            a_vld   <= 1'b0;
        end else if (clr) begin
            grp_cnt <= '0;
            a_vld   <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                acc <= sum_next;
                if (grp_cnt == LAST_CNT) begin
                    sum_reg <= sum_next;
                    a_vld   <= 1'b1;
                    grp_cnt <= '0;
                end else begin
                    a_vld   <= 1'b0;
                    grp_cnt <= grp_cnt + 1'b1;
                end
            end else begin
                a_vld <= 1'b0;
            end
        end
    end

    // Stage B datapath: multiply, round half up, shift, add zero point,
    // clamp. A 48-bit width holds the full product, so the rounding add
    // cannot overflow.
    always_comb begin
        sum_ext   = {{16{sum_reg[31]}}, sum_reg};
        scale_ext = {{(48 - SCALE_W){1'b0}}, scale};
        zp_ext    = {{40{zero_point[7]}}, zero_point};
        prod      = sum_ext * scale_ext;
        rnd       = '0;
        if (shift != '0) begin
            rnd = 48'sd1 <<< (shift - 1'b1);
        end
        shifted = (prod + rnd) >>> shift;
        v       = shifted + zp_ext;
`ifdef PPU_RELU_EN
        lo = zp_ext;
`else
        lo = -48'sd128;
`endif
        if (v > 48'sd127) begin
            q_next = 8'h7F;
        end else if (v < lo) begin
            q_next = lo[7:0];
        end else begin
            q_next = v[7:0];
        end
    end

    // Stage B register: capture the requantized byte one cycle after a_vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
            b_vld <= 1'b0;
        end else if (clr) begin
            b_vld <= 1'b0;
        end else if (!stall) begin
            b_vld <= a_vld;
            if (a_vld) begin
                q_reg <= q_next;
            end
        end
    end

    // Stage C: gather bytes into lanes and emit the word on the fourth
    // byte. A word that finishes in the same cycle as a handshake keeps
    // out_valid high. A stall and a finishing word never meet, because the
    // stall gates stage C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane        <= '0;
            lane_reg[0] <= '0;
            lane_reg[1] <= '0;
            lane_reg[2] <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clr) begin
                lane <= '0;
            end else if (!stall && b_vld) begin
                case (lane)
                    2'd0: lane_reg[0] <= q_reg;
                    2'd1: lane_reg[1] <= q_reg;
                    2'd2: lane_reg[2] <= q_reg;
                    default: begin
                        out_data  <= {q_reg, lane_reg[2], lane_reg[1], lane_reg[0]};
                        out_valid <= 1'b1;
                    end
                endcase
                lane <= lane + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ppu_requant.sv
// tb_ppu_requant
//
// Directed testbench for ppu_requant with ACC_LEN=9. It drives opsum
// groups whose sums are known and compares every emitted word against
// hand-computed packed bytes. It also covers reset values, latency,
// throughput, backpressure, asynchronous reset, clr and the optional
// PPU_RELU_EN clamp.
module tb_ppu_requant;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [31:0] opsum_in;
    logic        opsum_valid;
    logic        opsum_ready;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic [7:0]  zero_point;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int          tests_run;
    int          tests_failed;
    int          cyc;
    logic [31:0] got_q[$];

    ppu_requant #(
        .ACC_LEN(9),
        .SCALE_W(16),
        .SHIFT_W(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .opsum_in   (opsum_in),
        .opsum_valid(opsum_valid),
        .opsum_ready(opsum_ready),
        .scale      (scale),
        .shift      (shift),
        .zero_point (zero_point),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure opsum throughput.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor. Inputs only change 1 time unit after a rising edge,
    // so a valid & ready seen on the falling edge is the handshake that the
    // next rising edge completes.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(out_data);
        end
    end

    // Single comparison point: count it and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present one opsum and hold it until the DUT accepts it. Each call
    // returns 1 time unit after the accepting edge, so back-to-back calls
    // leave no bubble.
    task automatic applyStimulus(input logic [31:0] value);
        bit taken;
        taken       = 1'b0;
        opsum_valid = 1'b1;
        opsum_in    = value;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            taken = opsum_ready;
            @(posedge clk);
            #1;
            if (taken) break;
        end
        if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // One full 9-opsum group that sums to 'sum'.
    task automatic sendGroup(input int sum);
        applyStimulus(32'(sum - 24));
        for (int i = 0; i < 8; i++) applyStimulus(32'd3);
    endtask

    // Hold opsum_valid low for n cycles.
    task automatic idleCycles(input int n);
        opsum_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for the next captured word and compare it.
    task automatic expectWord(input string tag, input logic [31:0] expected);
        for (int i = 0; i < 100; i++) begin
            if (got_q.size() > 0) break;
            @(posedge clk);
            #1;
        end
        if (got_q.size() == 0) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput(tag, got_q.pop_front(), expected);
        end
    endtask

    // Main directed sequence.
    initial begin
        int start_cyc;
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        clr          = 1'b0;
        opsum_in     = '0;
        opsum_valid  = 1'b0;
        out_ready    = 1'b1;
        scale        = 16'd1;
        shift        = 5'd0;
        zero_point   = 8'd0;

        // Reset state
        #1;
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_opsum_ready", 32'(opsum_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("ready_before_edge", 32'(opsum_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_edge", 32'(opsum_ready), 32'd1);

        // Basic accumulate: 36 x 10 -> four sums of 90, with latency and throughput
        start_cyc = cyc;
        for (int i = 0; i < 36; i++) applyStimulus(32'd10);
        opsum_valid = 1'b0;
        checkOutput("throughput_cycles", 32'(cyc - start_cyc), 32'd36);
        checkOutput("lat_e0_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_e1_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_e2_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_e2_data", out_data, 32'h5A5A5A5A);
        expectWord("word_90s", 32'h5A5A5A5A);
        idleCycles(4);

        // Rounding with scale=3, shift=2
        scale = 16'd3;
        shift = 5'd2;
        sendGroup(90);
        sendGroup(-90);
        sendGroup(0);
        sendGroup(0);
        idleCycles(1);
        expectWord("word_round", 32'h0000BD44);
        idleCycles(4);

        // Saturation and accumulator wrap
        scale = 16'd1;
        shift = 5'd0;
        sendGroup(1000);
        sendGroup(-1000);
        applyStimulus(32'h7FFFFFFF);
        applyStimulus(32'd1);
        for (int i = 0; i < 7; i++) applyStimulus(32'd0);
        sendGroup(0);
        idleCycles(1);
        expectWord("word_sat", 32'h0080807F);
        idleCycles(4);

        // Zero point with saturation on both sides
        zero_point = 8'd10;
        sendGroup(120);
        sendGroup(0);
        sendGroup(-10);
        sendGroup(-200);
        idleCycles(1);
        expectWord("word_zp", 32'h80000A7F);
        idleCycles(4);

        // Optional ReLU clamp, zp=5
        zero_point = 8'd5;
        sendGroup(-50);
        sendGroup(0);
        sendGroup(200);
        sendGroup(-5);
        idleCycles(1);
`ifdef PPU_RELU_EN
        expectWord("word_relu", 32'h057F0505);
`else
        expectWord("word_relu", 32'h007F05D3);
`endif
        idleCycles(4);
        zero_point = 8'd0;

        // Backpressure: stall with opsums still in flight
        out_ready = 1'b0;
        fork
            begin
                for (int g = 1; g <= 8; g++) sendGroup(g);
                opsum_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    if (out_valid) break;
                    @(posedge clk);
                    #1;
                end
                checkOutput("bp_valid_seen", 32'(out_valid), 32'd1);
                checkOutput("bp_ready_low", 32'(opsum_ready), 32'd0);
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk);
                    #1;
                    checkOutput("bp_data_hold", out_data, 32'h04030201);
                end
                checkOutput("bp_valid_hold", 32'(out_valid), 32'd1);
                checkOutput("bp_no_early_hs", 32'(got_q.size()), 32'd0);
                out_ready = 1'b1;
            end
        join
        expectWord("bp_word1", 32'h04030201);
        expectWord("bp_word2", 32'h08070605);
        idleCycles(4);
        checkOutput("bp_no_dup", 32'(got_q.size()), 32'd0);

        // Asynchronous reset after five opsums
        for (int i = 0; i < 5; i++) applyStimulus(32'd10);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_out_data", out_data, 32'h0);
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_opsum_ready", 32'(opsum_ready), 32'd0);
        opsum_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        sendGroup(63);
        sendGroup(1);
        sendGroup(2);
        sendGroup(3);
        idleCycles(1);
        expectWord("word_after_rst", 32'h0302013F);
        idleCycles(4);

        // clr after two packed lanes and a partial group, with an opsum in the clr cycle
        sendGroup(11);
        sendGroup(12);
        for (int i = 0; i < 4; i++) applyStimulus(32'd100);
        idleCycles(4);
        clr         = 1'b1;
        opsum_valid = 1'b1;
        opsum_in    = 32'd50;
        @(posedge clk);
        #1;
        clr         = 1'b0;
        opsum_valid = 1'b0;
        sendGroup(21);
        sendGroup(22);
        sendGroup(23);
        sendGroup(24);
        idleCycles(1);
        expectWord("word_after_clr", 32'h18171615);
        idleCycles(10);
        checkOutput("no_extra_words", 32'(got_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
